// File: rtl/usbfifo_pkg.sv
// usbfifo_pkg: shared defaults, width constants and read-side state type
// for the USB FIFO responder.
package usbfifo_pkg;

    localparam int DEPTH_DEF  = 16;
    localparam int RD_DLY_DEF = 3;
    localparam int GAP_DEF    = 2;
    localparam int PTR_W_DEF  = $clog2(DEPTH_DEF);
    localparam int CNT_W_DEF  = PTR_W_DEF + 1;

    // Controller read strobe progress.
    typedef enum logic [1:0] {
        RS_IDLE,
        RS_DELAY,
        RS_DRIVE
    } rd_state_t;

    // Occupancy counter width for a FIFO of the given depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/usbfifo_sync.sv
// usbfifo_sync: single-clock FIFO with occupancy count. A push while full
// succeeds only when a pop happens in the same cycle; pops while empty and
// unmatched pushes while full are ignored, so contents are never corrupted.
module usbfifo_sync
    import usbfifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp];

    // Storage write; no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wp] <= din;
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wp <= wp + 1'b1;
            if (do_pop)
                rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/usb_fifo_responder.sv
// usb_fifo_responder: device side of an FT245-style byte FIFO bus. The host
// pushes bytes that the controller reads with RD strobes, and the controller
// writes bytes with WR strobes that the host pops.
// Optional build macro USBFIFO_STATUS_EN adds RX_CNT/TX_CNT occupancy outputs.
module usb_fifo_responder
    import usbfifo_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int RD_DLY = RD_DLY_DEF,
    parameter int GAP    = GAP_DEF
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RD,
    input  logic                   WR,
    inout  wire  [7:0]             USBX,
    output logic                   RXF,
    output logic                   TXE,
    input  logic [7:0]             HIN_DATA,
    input  logic                   HIN_VALID,
    output logic                   HIN_READY,
    output logic [7:0]             HOUT_DATA,
    output logic                   HOUT_VALID,
    input  logic                   HOUT_READY,
`ifdef USBFIFO_STATUS_EN
    output logic [$clog2(DEPTH):0] RX_CNT,
    output logic [$clog2(DEPTH):0] TX_CNT,
`endif
    output logic                   ERR
);

    localparam int CW = $clog2(DEPTH) + 1;

    rd_state_t     rd_st;
    logic          rd_q, wr_q;
    logic [7:0]    rd_cnt, rx_gap, tx_gap;
    logic          rd_pend, drive_q;
    logic [7:0]    dout_q, hold_q;
    logic          wr_arm, wr_bad, err_q;

    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]    rx_head;
    logic [CW-1:0] rx_cnt, tx_cnt;
    logic          rd_fall, rd_rise, wr_fall, conflict, tx_drop;

    assign rd_fall  = rd_q && !RD;
    assign rd_rise  = (rd_st != RS_IDLE) && RD;
    assign wr_fall  = wr_q && !WR;
    assign conflict = !RD && WR;

    // A pop in the same cycle frees a slot, so a full RX FIFO still accepts.
    assign rx_push   = HIN_VALID && HIN_READY;
    assign rx_pop    = rd_rise && rd_pend;
    assign HIN_READY = !rx_full || rx_pop;

    // Only strobes that started after reset push; a conflicted strobe is discarded.
    assign tx_push    = wr_fall && wr_arm && !wr_bad;
    assign tx_pop     = HOUT_VALID && HOUT_READY;
    assign tx_drop    = tx_push && tx_full && !tx_pop;
    assign HOUT_VALID = !tx_empty;

    assign RXF = rx_empty || (rx_gap != '0);
    assign TXE = tx_full  || (tx_gap != '0);
    assign ERR = err_q;

    // Bus is released the moment RD rises or the controller raises WR.
    assign USBX = (drive_q && !RD && !WR) ? dout_q : 8'hzz;

    usbfifo_sync #(.DEPTH(DEPTH), .W(8)) u_rx (
        .clk   (CLK),
        .rst   (RST),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (HIN_DATA),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_cnt)
    );

    usbfifo_sync #(.DEPTH(DEPTH), .W(8)) u_tx (
        .clk   (CLK),
        .rst   (RST),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (hold_q),
        .dout  (HOUT_DATA),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_cnt)
    );

`ifdef USBFIFO_STATUS_EN
    assign RX_CNT = rx_cnt;
    assign TX_CNT = tx_cnt;
`else
    logic [2*CW-1:0] unused_cnt;
    assign unused_cnt = {rx_cnt, tx_cnt};
`endif

    // Read strobe FSM: latch head on RD fall, drive after RD_DLY, pop on RD rise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_st   <= RS_IDLE;
            rd_cnt  <= '0;
            rd_pend <= 1'b0;
            drive_q <= 1'b0;
            dout_q  <= '0;
            rx_gap  <= '0;
        end else begin
            if (rx_gap != '0)
                rx_gap <= rx_gap - 1'b1;
            case (rd_st)
                RS_IDLE: begin
                    if (rd_fall) begin
                        dout_q  <= rx_empty ? 8'h00 : rx_head;
                        rd_pend <= !rx_empty;
                        rd_cnt  <= 8'd1;
                        if (RD_DLY <= 1) begin
                            rd_st   <= RS_DRIVE;
                            drive_q <= 1'b1;
                        end else begin
                            rd_st <= RS_DELAY;
                        end
                    end
                end
                RS_DELAY: begin
                    if (RD) begin
                        rd_st   <= RS_IDLE;
                        rd_pend <= 1'b0;
                        rx_gap  <= 8'(GAP);
                    end else begin
                        rd_cnt <= rd_cnt + 8'd1;
                        if (rd_cnt + 8'd1 >= 8'(RD_DLY)) begin
                            rd_st   <= RS_DRIVE;
                            drive_q <= 1'b1;
                        end
                    end
                end
                RS_DRIVE: begin
                    if (RD) begin
                        rd_st   <= RS_IDLE;
                        rd_pend <= 1'b0;
                        drive_q <= 1'b0;
                        rx_gap  <= 8'(GAP);
                    end
                end
                default: begin
                    rd_st   <= RS_IDLE;
                    drive_q <= 1'b0;
                end
            endcase
        end
    end

    // Strobe edge tracking, write capture, TX gap and sticky error.
    // wr_q resets high so a WR already high or low at reset release never
    // looks like a fresh strobe; rd_q resets low for the same reason.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b1;
            wr_arm <= 1'b0;
            wr_bad <= 1'b0;
            hold_q <= '0;
            tx_gap <= '0;
            err_q  <= 1'b0;
        end else begin
            rd_q <= RD;
            wr_q <= WR;
            if (WR)
                hold_q <= USBX;
            if (!wr_q && WR)
                wr_arm <= 1'b1;
            if (conflict)
                wr_bad <= 1'b1;
            if (wr_fall && wr_arm) begin
                wr_arm <= 1'b0;
                wr_bad <= 1'b0;
                tx_gap <= 8'(GAP);
            end else if (tx_gap != '0) begin
                tx_gap <= tx_gap - 1'b1;
            end
            if (conflict || tx_drop || (rd_st == RS_IDLE && rd_fall && rx_empty))
                err_q <= 1'b1;
        end
    end

endmodule
